// File: rtl/audio_rx_param_if.sv
// Audio receiver bus: serial pins, sample outputs, frame handshake.
// master = receiver side, slave = source/consumer side.
interface audio_rx_param_if #(
  parameter int DATA_WIDTH = 24
);
  logic                  en;
  logic                  i2s_mode;
  logic                  sck_bclk;
  logic                  ws_lrc;
  logic                  sdata;
  logic [DATA_WIDTH-1:0] left_data;
  logic [DATA_WIDTH-1:0] right_data;
  logic                  data_valid;
  logic                  data_ready;
  logic                  overrun;
  logic                  overrun_clr;
  logic                  frame_err;

  modport master (
    input  en, i2s_mode, sck_bclk, ws_lrc, sdata,
    input  data_ready, overrun_clr,
    output left_data, right_data, data_valid,
    output overrun, frame_err
  );

  modport slave (
    output en, i2s_mode, sck_bclk, ws_lrc, sdata,
    output data_ready, overrun_clr,
    input  left_data, right_data, data_valid,
    input  overrun, frame_err
  );
endinterface

// File: rtl/audio_rx_param.sv
// I2S / left-justified stereo receiver with frame handshake.
// Optional short-channel check: define AUDIO_RX_FRAME_CHK_EN.
module audio_rx_param #(
  parameter int DATA_WIDTH  = 24,
  parameter int SYNC_STAGES = 2,
  parameter bit LEFT_WS     = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  audio_rx_param_if.master  bus
);

  localparam int DW = DATA_WIDTH;
  localparam int SS = SYNC_STAGES;
  localparam logic [5:0] LJ_LAST  = 6'(DW - 1);
  localparam logic [5:0] I2S_LAST = 6'(DW);
  localparam logic [DW-1:0] MSB_ONE = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } state_e;

  logic [SS-1:0] sck_q, sck_d;
  logic [SS-1:0] wss_q, wss_d;
  logic [SS-1:0] sds_q, sds_d;
  logic          sck_prev_q, sck_prev_d;

  state_e        state_q, state_d;
  logic          ws_prev_q, ws_prev_d;
  logic          seen_q, seen_d;
  logic [5:0]    k_q, k_d;
  logic          mode_q, mode_d;
  logic [DW-1:0] shl_q, shl_d;
  logic [DW-1:0] shr_q, shr_d;
  logic [DW-1:0] left_q, left_d;
  logic [DW-1:0] right_q, right_d;
  logic          valid_q, valid_d;
  logic          ovr_q, ovr_d;
`ifdef AUDIO_RX_FRAME_CHK_EN
  logic          ferr_q, ferr_d;
  logic          bad_q, bad_d;
  logic          short_c;
`endif

  logic          rise;
  logic          ws_s;
  logic          sd_s;
  logic          chg;
  logic          emit;
  logic          in_win;
  logic [5:0]    pos;
  logic [DW-1:0] onehot;

  // Synchroniser chains; sdata rides the same depth as bclk/ws
  always_comb begin
    sck_d      = {sck_q[SS-2:0], bus.sck_bclk};
    wss_d      = {wss_q[SS-2:0], bus.ws_lrc};
    sds_d      = {sds_q[SS-2:0], bus.sdata};
    sck_prev_d = sck_q[SS-1];
    rise       = sck_q[SS-1] & ~sck_prev_q;
    ws_s       = wss_q[SS-1];
    sd_s       = sds_q[SS-1];
  end

  // Bit counter, channel FSM, capture and frame handshake
  always_comb begin
    state_d   = state_q;
    ws_prev_d = ws_prev_q;
    seen_d    = seen_q;
    k_d       = k_q;
    mode_d    = mode_q;
    shl_d     = shl_q;
    shr_d     = shr_q;
    left_d    = left_q;
    right_d   = right_q;
    valid_d   = valid_q;
    ovr_d     = ovr_q;
    emit      = 1'b0;
    in_win    = 1'b0;
    pos       = 6'd0;
    onehot    = '0;
`ifdef AUDIO_RX_FRAME_CHK_EN
    ferr_d    = 1'b0;
    bad_d     = bad_q;
    short_c   = k_q < (mode_q ? I2S_LAST : LJ_LAST);
`endif

    // first sampled ws after reset only primes the edge detector
    chg = rise & seen_q & (ws_s != ws_prev_q);

    if (rise) begin
      ws_prev_d = ws_s;
      seen_d    = 1'b1;
      if (chg)
        k_d = 6'd0;
      else if (k_q != 6'd63)
        k_d = k_q + 6'd1;
    end

    if (!bus.en) begin
      state_d = HUNT;
    end else begin
      unique case (state_q)
        HUNT: begin
          if (chg && (ws_s == LEFT_WS)) begin
            state_d = LEFT;
            mode_d  = bus.i2s_mode;
            shl_d   = '0;
`ifdef AUDIO_RX_FRAME_CHK_EN
            bad_d   = 1'b0;
`endif
          end
        end
        LEFT: begin
          if (chg) begin
            state_d = RIGHT;
            shr_d   = '0;
`ifdef AUDIO_RX_FRAME_CHK_EN
            if (short_c) begin
              ferr_d = 1'b1;
              bad_d  = 1'b1;
            end
`endif
          end
        end
        RIGHT: begin
          if (chg) begin
            state_d = LEFT;
            shl_d   = '0;
`ifdef AUDIO_RX_FRAME_CHK_EN
            ferr_d  = short_c;
            emit    = !bad_q && !short_c;
            bad_d   = 1'b0;
`else
            emit    = 1'b1;
`endif
          end
        end
        default: state_d = HUNT;
      endcase
    end

    // place the sampled bit at its MSB-aligned position
    if (rise && bus.en && (state_d != HUNT)) begin
      if (mode_d) begin
        in_win = (k_d != 6'd0) && (k_d <= I2S_LAST);
        pos    = k_d - 6'd1;
      end else begin
        in_win = k_d <= LJ_LAST;
        pos    = k_d;
      end
      onehot = MSB_ONE >> pos;
      if (in_win) begin
        if (state_d == LEFT)
          shl_d = sd_s ? (shl_d | onehot) : (shl_d & ~onehot);
        else
          shr_d = sd_s ? (shr_d | onehot) : (shr_d & ~onehot);
      end
    end

    if (bus.overrun_clr)
      ovr_d = 1'b0;

    if (emit) begin
      left_d  = shl_q;
      right_d = shr_q;
      valid_d = 1'b1;
      if (valid_q && !bus.data_ready)
        ovr_d = 1'b1;
    end else if (valid_q && bus.data_ready) begin
      valid_d = 1'b0;
    end
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_q      <= '0;
      wss_q      <= '0;
      sds_q      <= '0;
      sck_prev_q <= 1'b0;
      state_q    <= HUNT;
      ws_prev_q  <= 1'b0;
      seen_q     <= 1'b0;
      k_q        <= 6'd0;
      mode_q     <= 1'b0;
      shl_q      <= '0;
      shr_q      <= '0;
      left_q     <= '0;
      right_q    <= '0;
      valid_q    <= 1'b0;
      ovr_q      <= 1'b0;
`ifdef AUDIO_RX_FRAME_CHK_EN
      ferr_q     <= 1'b0;
      bad_q      <= 1'b0;
`endif
    end else begin
      sck_q      <= sck_d;
      wss_q      <= wss_d;
      sds_q      <= sds_d;
      sck_prev_q <= sck_prev_d;
      state_q    <= state_d;
      ws_prev_q  <= ws_prev_d;
      seen_q     <= seen_d;
      k_q        <= k_d;
      mode_q     <= mode_d;
      shl_q      <= shl_d;
      shr_q      <= shr_d;
      left_q     <= left_d;
      right_q    <= right_d;
      valid_q    <= valid_d;
      ovr_q      <= ovr_d;
`ifdef AUDIO_RX_FRAME_CHK_EN
      ferr_q     <= ferr_d;
      bad_q      <= bad_d;
`endif
    end
  end

  assign bus.left_data  = left_q;
  assign bus.right_data = right_q;
  assign bus.data_valid = valid_q;
  assign bus.overrun    = ovr_q;
`ifdef AUDIO_RX_FRAME_CHK_EN
  assign bus.frame_err  = ferr_q;
`else
  assign bus.frame_err  = 1'b0;
`endif

endmodule

// File: tb/tb_audio_rx_param.sv
// Directed bench for audio_rx_param (DATA_WIDTH=24, SYNC=2).
// Serial stream driven bit by bit; bclk = clk/8.
module tb_audio_rx_param;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   ferr_cnt;

  audio_rx_param_if #(.DATA_WIDTH(24)) bus();

  audio_rx_param #(
    .DATA_WIDTH(24),
    .SYNC_STAGES(2),
    .LEFT_WS(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk)
    if (bus.frame_err === 1'b1) ferr_cnt++;

  initial begin
    #3000000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [31:0] l;
    logic [31:0] r;
    int          nbits;
    int          slot;
    logic        i2s;
    logic        short_f;
    logic [23:0] el;
    logic [23:0] er;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic w, input logic b);
    @(negedge clk);
    bus.sck_bclk = 1'b0;
    bus.ws_lrc   = w;
    bus.sdata    = b;
    repeat (3) @(negedge clk);
    bus.sck_bclk = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_chan(input logic w, input logic [31:0] val,
                           input int nbits, input int slot,
                           input logic i2s, input int j0,
                           input int j1);
    int   idx;
    logic b;
    for (int j = j0; j < j1 && j < slot; j++) begin
      idx = i2s ? j - 1 : j;
      b = 1'b0;
      if (idx >= 0 && idx < nbits) b = val[nbits-1-idx];
      send_bit(w, b);
    end
  endtask

  task automatic send_frame(input logic [31:0] l, input logic [31:0] r,
                            input int nbits, input int slot,
                            input logic i2s);
    send_chan(1'b1, l, nbits, slot, i2s, 0, slot);
    send_chan(1'b0, r, nbits, slot, i2s, 0, slot);
  endtask

  // ws change back to left closes the pair
  task automatic trigger();
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    repeat (4) @(negedge clk);
  endtask

  // drop en to force HUNT, pick mode, then a short right preamble
  task automatic restart(input logic i2s);
    @(negedge clk);
    bus.en = 1'b0;
    repeat (4) @(negedge clk);
    bus.i2s_mode = i2s;
    bus.en = 1'b1;
    send_chan(1'b0, 32'd0, 0, 4, 1'b0, 0, 4);
  endtask

  task automatic handshake();
    @(negedge clk);
    bus.data_ready = 1'b1;
    @(negedge clk);
    bus.data_ready = 1'b0;
  endtask

  logic [23:0] exp_l, exp_r;
  logic        exp_v;
  int          exp_ferr;

  initial begin
    checks   = 0;
    errors   = 0;
    ferr_cnt = 0;
    exp_ferr = 0;
    exp_l    = '0;
    exp_r    = '0;

    vecs[0] = '{32'hABCDEF, 32'h123456, 24, 32, 1'b1, 1'b0,
                24'hABCDEF, 24'h123456};
    vecs[1] = '{32'hABCDEF, 32'h123456, 24, 32, 1'b0, 1'b0,
                24'hABCDEF, 24'h123456};
    vecs[2] = '{32'h0000FFFF, 32'h00008001, 16, 16, 1'b0, 1'b1,
                24'hFFFF00, 24'h800100};
    vecs[3] = '{32'h000001, 32'h800000, 24, 24, 1'b0, 1'b0,
                24'h000001, 24'h800000};
    vecs[4] = '{32'h5A5A5A, 32'hA5A5A5, 24, 25, 1'b1, 1'b0,
                24'h5A5A5A, 24'hA5A5A5};
    vecs[5] = '{32'hDEADBEEF, 32'hCAFEF00D, 32, 32, 1'b0, 1'b0,
                24'hDEADBE, 24'hCAFEF0};

    rst             = 1'b1;
    bus.en          = 1'b0;
    bus.i2s_mode    = 1'b0;
    bus.sck_bclk    = 1'b0;
    bus.ws_lrc      = 1'b0;
    bus.sdata       = 1'b0;
    bus.data_ready  = 1'b0;
    bus.overrun_clr = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_left", 32'(bus.left_data), 32'h0);
    chk("rst_right", 32'(bus.right_data), 32'h0);
    chk("rst_valid", 32'(bus.data_valid), 32'h0);
    chk("rst_overrun", 32'(bus.overrun), 32'h0);
    chk("rst_ferr", 32'(bus.frame_err), 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      restart(vecs[i].i2s);
      send_frame(vecs[i].l, vecs[i].r, vecs[i].nbits,
                 vecs[i].slot, vecs[i].i2s);
      trigger();
      exp_v = 1'b1;
`ifdef AUDIO_RX_FRAME_CHK_EN
      if (vecs[i].short_f) begin
        exp_v = 1'b0;
        exp_ferr += 2;
      end
`endif
      if (exp_v) begin
        exp_l = vecs[i].el;
        exp_r = vecs[i].er;
      end
      chk($sformatf("vec%0d_left", i), 32'(bus.left_data), 32'(exp_l));
      chk($sformatf("vec%0d_right", i), 32'(bus.right_data), 32'(exp_r));
      chk($sformatf("vec%0d_valid", i), 32'(bus.data_valid), 32'(exp_v));
      handshake();
      chk($sformatf("vec%0d_valid_clr", i), 32'(bus.data_valid), 32'h0);
    end

    // overrun: two frames with no handshake
    restart(1'b1);
    send_frame(32'h111111, 32'h222222, 24, 32, 1'b1);
    send_frame(32'h333333, 32'h444444, 24, 32, 1'b1);
    trigger();
    chk("ovr_set", 32'(bus.overrun), 32'h1);
    chk("ovr_left", 32'(bus.left_data), 32'h333333);
    chk("ovr_right", 32'(bus.right_data), 32'h444444);
    chk("ovr_valid", 32'(bus.data_valid), 32'h1);
    @(negedge clk);
    bus.overrun_clr = 1'b1;
    @(negedge clk);
    bus.overrun_clr = 1'b0;
    chk("ovr_clr", 32'(bus.overrun), 32'h0);
    chk("ovr_valid_kept", 32'(bus.data_valid), 32'h1);

    // reset in the middle of the right channel
    restart(1'b1);
    send_chan(1'b1, 32'h777777, 24, 32, 1'b1, 0, 32);
    send_chan(1'b0, 32'h888888, 24, 32, 1'b1, 0, 10);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_left", 32'(bus.left_data), 32'h0);
    chk("mid_rst_right", 32'(bus.right_data), 32'h0);
    chk("mid_rst_valid", 32'(bus.data_valid), 32'h0);
    chk("mid_rst_ovr", 32'(bus.overrun), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    send_chan(1'b0, 32'h888888, 24, 32, 1'b1, 10, 32);
    send_frame(32'h13579B, 32'h2468AC, 24, 32, 1'b1);
    repeat (4) @(negedge clk);
    chk("post_rst_no_emit", 32'(bus.data_valid), 32'h0);
    trigger();
    chk("post_rst_left", 32'(bus.left_data), 32'h13579B);
    chk("post_rst_right", 32'(bus.right_data), 32'h2468AC);
    chk("post_rst_valid", 32'(bus.data_valid), 32'h1);
    handshake();

    // en dropped mid-right, raised mid-left
    restart(1'b1);
    send_chan(1'b1, 32'h0F0F0F, 24, 32, 1'b1, 0, 32);
    send_chan(1'b0, 32'hF0F0F0, 24, 32, 1'b1, 0, 10);
    bus.en = 1'b0;
    send_chan(1'b0, 32'hF0F0F0, 24, 32, 1'b1, 10, 32);
    send_chan(1'b1, 32'h111111, 24, 32, 1'b1, 0, 10);
    bus.en = 1'b1;
    send_chan(1'b1, 32'h111111, 24, 32, 1'b1, 10, 32);
    send_chan(1'b0, 32'h222222, 24, 32, 1'b1, 0, 32);
    trigger();
    chk("en_no_emit", 32'(bus.data_valid), 32'h0);
    chk("en_hold_left", 32'(bus.left_data), 32'h13579B);
    send_chan(1'b1, 32'h654321, 24, 32, 1'b1, 2, 32);
    send_chan(1'b0, 32'h0FEDCB, 24, 32, 1'b1, 0, 32);
    trigger();
    chk("en_left", 32'(bus.left_data), 32'h654321);
    chk("en_right", 32'(bus.right_data), 32'h0FEDCB);
    chk("en_valid", 32'(bus.data_valid), 32'h1);
    handshake();

    chk("ferr_count", 32'(ferr_cnt), 32'(exp_ferr));

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
